output_argmax: RTL and testbench

// - Reader on the downstream side of a dense layer: consumes the parallel outputs vector and its level

---
 rtl/output_argmax_if.sv | 21 ++
 rtl/output_argmax.sv | 66 ++++++
 tb/tb_output_argmax.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/output_argmax_if.sv
// output_argmax_if: scores vector, level ready flag and classification result between a dense layer and output_argmax.
// The max_value signal exists only when ARGMAX_MAX_VALUE_EN is defined.
interface output_argmax_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_INPUTS = 10
);
   localparam int INDEX_WIDTH = $clog2(NUM_INPUTS);
   logic                         inputs_ready;
   logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS];
   logic [INDEX_WIDTH-1:0]       class_index;
   logic                         class_ready;
   logic                         busy;
`ifdef ARGMAX_MAX_VALUE_EN
   logic signed [DATA_WIDTH-1:0] max_value;
   modport master (output inputs_ready, inputs, input class_index, class_ready, busy, max_value);
   modport slave (input inputs_ready, inputs, output class_index, class_ready, busy, max_value);
`else
   modport master (output inputs_ready, inputs, input class_index, class_ready, busy);
   modport slave (input inputs_ready, inputs, output class_index, class_ready, busy);
`endif
endinterface

// File: rtl/output_argmax.sv
// output_argmax: sequential signed argmax over a captured score vector, one compare per clock.
// Define ARGMAX_MAX_VALUE_EN to also publish the winning score on max_value.
module output_argmax #(
   parameter int INTG_WIDTH = 16,
   parameter int FRAC_WIDTH = 16,
   parameter int NUM_INPUTS = 10
) (
   input logic clock,
   input logic reset,
   output_argmax_if.slave bus
);
   localparam int DATA_WIDTH  = INTG_WIDTH + FRAC_WIDTH;
   localparam int INDEX_WIDTH = $clog2(NUM_INPUTS);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, state_nxt;
   logic ready_q, start, capture, greater, last;
   logic signed [DATA_WIDTH-1:0] cap [NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0] best;
   logic [INDEX_WIDTH-1:0] idx, best_idx, class_index;
   assign start   = bus.inputs_ready & ~ready_q;
   assign capture = start && state != SCAN;
   assign greater = cap[idx] > best;
   assign last    = idx == INDEX_WIDTH'(NUM_INPUTS - 1);
   always_ff @(posedge clock)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   always_comb
      state_nxt = state == SCAN ? (last ? DONE : SCAN) : (start ? SCAN : IDLE);
   always_comb begin
      bus.busy        = state == SCAN;
      bus.class_ready = state == DONE;
   end
   // The vector is frozen at the trigger edge so later input changes cannot disturb a scan.
   always_ff @(posedge clock)
      if (reset && capture) cap <= bus.inputs;
   always_ff @(posedge clock)
      if (!reset) begin
         ready_q     <= 1'b0;
         best        <= '0;
         best_idx    <= '0;
         idx         <= '0;
         class_index <= '0;
      end else begin
         ready_q <= bus.inputs_ready;
         if (capture) begin
            best     <= bus.inputs[0];
            best_idx <= '0;
            idx      <= INDEX_WIDTH'(1);
         end else if (state == SCAN) begin
            if (greater) begin
               best     <= cap[idx];
               best_idx <= idx;
            end
            idx <= idx + 1'b1;
            if (last) class_index <= greater ? idx : best_idx;
         end
      end
   assign bus.class_index = class_index;
`ifdef ARGMAX_MAX_VALUE_EN
   logic signed [DATA_WIDTH-1:0] max_value;
   always_ff @(posedge clock)
      if (!reset) max_value <= '0;
      else if (state == SCAN && last) max_value <= greater ? cap[idx] : best;
   assign bus.max_value = max_value;
`endif
endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax: directed self-checking bench for output_argmax with hand-computed expected classes.
module tb_output_argmax;
   logic clock, reset;
   int compared, mismatched;
   output_argmax_if #(.DATA_WIDTH(32), .NUM_INPUTS(10)) bus ();
   output_argmax #(.INTG_WIDTH(16), .FRAC_WIDTH(16), .NUM_INPUTS(10)) dut (
      .clock(clock), .reset(reset), .bus(bus));
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < 10; i++) bus.inputs[i] = v;
   endtask
   // Scores {0,1,2,3,4,-1,2,5,3,4} as integers: maximum 5.0 at index 7.
   task automatic load_basic();
      int s [10] = '{0, 1, 2, 3, 4, -1, 2, 5, 3, 4};
      for (int i = 0; i < 10; i++) bus.inputs[i] = 32'(s[i]) <<< 16;
   endtask
   task automatic load_max9();
      for (int i = 0; i < 10; i++) bus.inputs[i] = 32'(i) <<< 16;
   endtask
   task automatic observe(input int n, output int pulses, output int first, output int busy_n,
                          output logic [3:0] cidx);
      pulses = 0; first = 0; busy_n = 0; cidx = '0;
      for (int j = 1; j <= n; j++) begin
         @(negedge clock);
         if (bus.busy) busy_n++;
         if (bus.class_ready) begin
            pulses++;
            if (first == 0) first = j;
            cidx = bus.class_index;
         end
      end
   endtask
   task automatic idle(input int n);
      bus.inputs_ready = 1'b0;
      repeat (n) @(negedge clock);
   endtask
   task automatic test_reset();
      reset = 1'b0; bus.inputs_ready = 1'b0; fill('0);
      repeat (3) @(negedge clock);
      compared++; if (bus.class_index !== 4'd0) begin mismatched++; $display("FAIL reset_index got %0d want 0", bus.class_index); end
      compared++; if (bus.class_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", bus.class_ready); end
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      reset = 1'b1;
      @(negedge clock);
   endtask
   task automatic test_basic();
      int p, f, b; logic [3:0] c;
      load_basic(); bus.inputs_ready = 1'b1;
      observe(14, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL basic_pulses got %0d want 1", p); end
      compared++; if (f !== 10) begin mismatched++; $display("FAIL basic_latency got %0d want 10", f); end
      compared++; if (b !== 9) begin mismatched++; $display("FAIL basic_busy got %0d want 9", b); end
      compared++; if (c !== 4'd7) begin mismatched++; $display("FAIL basic_index got %0d want 7", c); end
      idle(2);
   endtask
   task automatic test_ties_signs();
      int p, f, b; logic [3:0] c;
      fill(32'hFFFD_0000); bus.inputs[2] = 32'hFFFF_0000; bus.inputs[6] = 32'hFFFF_0000;
      bus.inputs_ready = 1'b1;
      observe(12, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL tie_pulses got %0d want 1", p); end
      compared++; if (c !== 4'd2) begin mismatched++; $display("FAIL tie_index got %0d want 2", c); end
      idle(2);
      fill(32'h8000_0000); bus.inputs_ready = 1'b1;
      observe(12, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL minneg_pulses got %0d want 1", p); end
      compared++; if (c !== 4'd0) begin mismatched++; $display("FAIL minneg_index got %0d want 0", c); end
      idle(2);
   endtask
   task automatic test_level_hold();
      int p, f, b; logic [3:0] c;
      load_basic(); bus.inputs_ready = 1'b1;
      observe(50, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL hold_pulses got %0d want 1", p); end
      compared++; if (c !== 4'd7) begin mismatched++; $display("FAIL hold_index got %0d want 7", c); end
      idle(1);
      load_max9(); bus.inputs_ready = 1'b1;
      observe(12, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL retrig_pulses got %0d want 1", p); end
      compared++; if (c !== 4'd9) begin mismatched++; $display("FAIL retrig_index got %0d want 9", c); end
      idle(2);
   endtask
   task automatic test_mid_scan();
      int p, f, b; logic [3:0] c;
      load_basic(); bus.inputs_ready = 1'b1;
      @(negedge clock);
      fill(32'hFFF0_0000); bus.inputs[1] = 32'h0064_0000; bus.inputs_ready = 1'b0;
      @(negedge clock);
      bus.inputs_ready = 1'b1;
      observe(20, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL mid_pulses got %0d want 1", p); end
      compared++; if (f !== 8) begin mismatched++; $display("FAIL mid_latency got %0d want 8", f); end
      compared++; if (c !== 4'd7) begin mismatched++; $display("FAIL mid_index got %0d want 7", c); end
      idle(2);
   endtask
   task automatic test_reset_mid_scan();
      int p, f, b; logic [3:0] c;
      load_basic(); bus.inputs_ready = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      compared++; if (bus.class_index !== 4'd0) begin mismatched++; $display("FAIL rst_mid_index got %0d want 0", bus.class_index); end
      compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
      compared++; if (bus.class_ready !== 1'b0) begin mismatched++; $display("FAIL rst_mid_ready got %b want 0", bus.class_ready); end
      reset = 1'b1;
      observe(20, p, f, b, c);
      compared++; if (p !== 1) begin mismatched++; $display("FAIL rst_rel_pulses got %0d want 1", p); end
      compared++; if (f !== 10) begin mismatched++; $display("FAIL rst_rel_latency got %0d want 10", f); end
      compared++; if (c !== 4'd7) begin mismatched++; $display("FAIL rst_rel_index got %0d want 7", c); end
      idle(2);
   endtask
   task automatic test_back_to_back();
      int p1, p2, n; logic [3:0] c1, c2;
      p1 = 0; p2 = 0; n = 0; c1 = '0; c2 = '0;
      load_basic(); bus.inputs_ready = 1'b1;
      for (int j = 1; j <= 25; j++) begin
         @(negedge clock);
         if (bus.class_ready) begin
            n++;
            if (p1 == 0) begin p1 = j; c1 = bus.class_index; end
            else begin p2 = j; c2 = bus.class_index; end
         end
         if (j == 1) bus.inputs_ready = 1'b0;
         if (j == 10) begin load_max9(); bus.inputs_ready = 1'b1; end
      end
      compared++; if (n !== 2) begin mismatched++; $display("FAIL b2b_pulses got %0d want 2", n); end
      compared++; if (p1 !== 10 || c1 !== 4'd7) begin mismatched++; $display("FAIL b2b_first got cycle %0d idx %0d want cycle 10 idx 7", p1, c1); end
      compared++; if (p2 !== 20 || c2 !== 4'd9) begin mismatched++; $display("FAIL b2b_second got cycle %0d idx %0d want cycle 20 idx 9", p2, c2); end
      idle(2);
   endtask
`ifdef ARGMAX_MAX_VALUE_EN
   task automatic test_max_value();
      logic [31:0] mv; int n;
      mv = '0; n = 0;
      fill(32'h0001_0000); bus.inputs[3] = 32'h000C_4000; bus.inputs[8] = 32'h000C_0000;
      bus.inputs_ready = 1'b1;
      for (int j = 1; j <= 12; j++) begin
         @(negedge clock);
         if (bus.class_ready) begin n++; mv = bus.max_value; end
      end
      compared++; if (n !== 1 || mv !== 32'h000C_4000) begin mismatched++; $display("FAIL max_value got %h (pulses %0d) want 000c4000", mv, n); end
      idle(2);
   endtask
`endif
   initial begin
      compared = 0; mismatched = 0;
      test_reset();
      test_basic();
      test_ties_signs();
      test_level_hold();
      test_mid_scan();
      test_reset_mid_scan();
      test_back_to_back();
`ifdef ARGMAX_MAX_VALUE_EN
      test_max_value();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
